// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit sitting between the EX/MEM register and a 2^ADDR_W x 32 data memory.
// Sub-word stores run as a two-cycle read-modify-write. Loads are aligned, extended and registered.
// Misaligned or illegal-width requests raise access_err and never strobe memory.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req_valid/read/write   request qualifiers (write wins over read)
//   funct3, addr, wdata    RV32I width code, byte address, store data
//   mem_rdata              word returned by memory (sampled on falling edge)
//   mem_addr/read/write    word index and strobes to memory
//   mem_wdata              word to memory
//   stall                  holds the pipeline during the RMW read cycle
//   load_data/load_valid   registered load result and its one-cycle pulse
//   access_err             registered one-cycle error pulse
module lsu_mem_stage #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              access_err
);

  typedef enum logic [0:0] {StIdle, StRmwWrite} state_e;

  state_e            state_q, state_d;
  logic [31:0]       wbuf_q, wbuf_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              access_err_q, access_err_d;

  logic        is_wr, is_rd;
  logic        f3_legal, misaligned, req_err, sub_store;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext, merged;
  logic        unused_addr_hi;

  // Address bits above the word index are don't-care.
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign is_wr = req_valid & req_write;
  assign is_rd = req_valid & req_read & ~req_write;

  always_comb begin
    f3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~req_write;  // unsigned widths exist for loads only
      default:                f3_legal = 1'b0;
    endcase
  end

  assign misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign req_err    = (is_wr | is_rd) & (~f3_legal | misaligned);
  assign sub_store  = is_wr & ~req_err & (funct3[1:0] != 2'b10);

  // Load lane selection and extension; funct3[2] marks the unsigned variants.
  always_comb begin
    lane_b = mem_rdata[{addr[1:0], 3'b000} +: 8];
    lane_h = addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3[1:0])
      2'b00:   load_ext = {{24{lane_b[7] & ~funct3[2]}}, lane_b};
      2'b01:   load_ext = {{16{lane_h[15] & ~funct3[2]}}, lane_h};
      default: load_ext = mem_rdata;
    endcase
  end

  // Word read during the first RMW cycle with the target lane overwritten.
  always_comb begin
    merged = mem_rdata;
    if (funct3[1:0] == 2'b00) begin
      merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    end else begin
      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (sub_store) state_d = StRmwWrite;
      StRmwWrite: state_d = StIdle;
    endcase
  end

  // Output logic; strobes are forced low while in reset.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    stall     = 1'b0;
    mem_wdata = wdata;
    mem_addr  = addr[ADDR_W+1:2];
    case (state_q)
      StIdle: begin
        if (!rst && !req_err) begin
          if (sub_store) begin
            mem_read = 1'b1;
            stall    = 1'b1;
          end else if (is_wr) begin
            mem_write = 1'b1;
          end else if (is_rd) begin
            mem_read = 1'b1;
          end
        end
      end
      StRmwWrite: begin
        mem_wdata = wbuf_q;
        mem_addr  = waddr_q;
        mem_write = ~rst;
      end
    endcase
  end

  // Datapath next-state.
  always_comb begin
    wbuf_d       = wbuf_q;
    waddr_d      = waddr_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    access_err_d = 1'b0;
    if (state_q == StIdle) begin
      access_err_d = req_err;
      if (sub_store) begin
        wbuf_d  = merged;
        waddr_d = addr[ADDR_W+1:2];
      end
      if (is_rd) begin
        load_valid_d = 1'b1;
        load_data_d  = req_err ? 32'd0 : load_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbuf_q       <= '0;
      waddr_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      access_err_q <= 1'b0;
    end else begin
      wbuf_q       <= wbuf_d;
      waddr_q      <= waddr_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      access_err_q <= access_err_d;
    end
  end

  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign access_err = access_err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: stimulus pushes expected memory writes, load results and
// error pulses (each tagged with the cycle it is due); a negedge monitor pops and compares.
module tb_lsu_mem_stage;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_read, req_write;
  logic [2:0]    funct3;
  logic [31:0]   addr, wdata;
  logic [31:0]   mem_rdata = 32'd0;
  logic [AW-1:0] mem_addr;
  logic          mem_read, mem_write, stall;
  logic [31:0]   mem_wdata, load_data;
  logic          load_valid, access_err;

  always #5 clk = ~clk;

  lsu_mem_stage #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_read   (req_read),
    .req_write  (req_write),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .access_err (access_err)
  );

  typedef struct {
    int          due;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  exp_t        wr_q[$];
  exp_t        ld_q[$];
  exp_t        er_q[$];
  exp_t        me;
  logic [31:0] dmem    [256];
  logic [31:0] ref_mem [256];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Data memory: strobes sampled and read data driven on the falling edge.
  initial for (int i = 0; i < 256; i++) dmem[i] = 32'd0;
  always @(negedge clk) begin
    if (mem_write) dmem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= dmem[mem_addr];
  end

  // Monitor.
  always @(negedge clk) begin
    if (rst) chk("rst_strobes", {29'd0, mem_read, mem_write, stall}, 32'd0);
    if (mem_write) begin
      chk("strobe_excl", 32'(mem_read), 32'd0);
      if (wr_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_write), 32'd0);
      end else begin
        me = wr_q.pop_front();
        chk("write_addr", 32'(mem_addr), me.a);
        chk("write_data", mem_wdata, me.d);
        chk("write_cycle", cyc, me.due);
      end
    end else if (wr_q.size() != 0 && wr_q[0].due <= cyc) begin
      chk("missing_write", 32'(mem_write), 32'd1);
      void'(wr_q.pop_front());
    end
    if (load_valid) begin
      if (ld_q.size() == 0) begin
        chk("unexpected_load_valid", 32'(load_valid), 32'd0);
      end else begin
        me = ld_q.pop_front();
        chk("load_data", load_data, me.d);
        chk("load_cycle", cyc, me.due);
      end
    end else if (ld_q.size() != 0 && ld_q[0].due <= cyc) begin
      chk("missing_load_valid", 32'(load_valid), 32'd1);
      void'(ld_q.pop_front());
    end
    if (access_err) begin
      if (er_q.size() == 0) begin
        chk("unexpected_access_err", 32'(access_err), 32'd0);
      end else begin
        me = er_q.pop_front();
        chk("err_cycle", cyc, me.due);
      end
    end else if (er_q.size() != 0 && er_q[0].due <= cyc) begin
      chk("missing_access_err", 32'(access_err), 32'd1);
      void'(er_q.pop_front());
    end
  end

  // Issue one request and record what memory and the load/error outputs should do.
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    logic        is_wr, is_rd, legal, mis, err, sub;
    int          k, sz, off, idx;
    logic [31:0] w, mask, val;
    exp_t        e;
    @(posedge clk); #1;
    req_valid = v; req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    k     = cyc;
    is_wr = v && wr;
    is_rd = v && rd && !wr;
    if (is_wr) legal = (f3 <= 3'd2);
    else       legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = 1 << f3[1:0];
    mis = (a % sz) != 0;
    err = (is_wr || is_rd) && (!legal || mis);
    sub = is_wr && !err && sz < 4;
    idx = int'((a >> 2) % 256);
    off = int'(a % 4);
    if (err) begin
      e = '{due: k + 1, a: 32'd0, d: 32'd0};
      er_q.push_back(e);
      if (is_rd) ld_q.push_back(e);
    end else if (is_wr) begin
      w = ref_mem[idx];
      if (sz == 4) begin
        w = wd;
      end else begin
        mask = ((32'd1 << (8 * sz)) - 32'd1) << (8 * off);
        w    = (w & ~mask) | ((wd << (8 * off)) & mask);
      end
      ref_mem[idx] = w;
      e = '{due: (sub ? k + 1 : k), a: 32'(idx), d: w};
      wr_q.push_back(e);
    end else if (is_rd) begin
      val = ref_mem[idx] >> (8 * off);
      if (sz == 1)      val = f3[2] ? {24'd0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
      else if (sz == 2) val = f3[2] ? {16'd0, val[15:0]} : {{16{val[15]}}, val[15:0]};
      e = '{due: k + 1, a: 32'd0, d: val};
      ld_q.push_back(e);
    end
    @(negedge clk);
    chk("stall", 32'(stall), 32'(sub));
    chk("mem_read", 32'(mem_read), 32'((is_rd && !err) || sub));
    chk("mem_write_first", 32'(mem_write), 32'(is_wr && !err && !sub));
    if (mem_read) chk("read_addr", 32'(mem_addr), 32'(idx));
    if (sub) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_rmw", 32'(stall), 32'd0);
      chk("mem_read_rmw", 32'(mem_read), 32'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
    rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_load_data", load_data, 32'd0);
    chk("reset_load_valid", 32'(load_valid), 32'd0);
    chk("reset_access_err", 32'(access_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Word store then load.
    do_op(1, 0, 1, 3'd2, 32'h10, 32'hDEADBEEF);
    do_op(1, 1, 0, 3'd2, 32'h10, 32'd0);
    // Byte store via RMW, then unsigned byte load.
    do_op(1, 0, 1, 3'd0, 32'h11, 32'h55);
    do_op(1, 1, 0, 3'd4, 32'h11, 32'd0);
    do_op(1, 1, 0, 3'd2, 32'h10, 32'd0);
    // Extension cases.
    do_op(1, 0, 1, 3'd2, 32'h10, 32'h80FF0000);
    do_op(1, 1, 0, 3'd0, 32'h13, 32'd0);
    do_op(1, 1, 0, 3'd5, 32'h12, 32'd0);
    do_op(1, 1, 0, 3'd1, 32'h12, 32'd0);
    // Errors: misaligned word load, misaligned half store, illegal funct3 load and store.
    do_op(1, 1, 0, 3'd2, 32'h12, 32'd0);
    do_op(1, 0, 1, 3'd1, 32'h13, 32'h1234);
    do_op(1, 1, 0, 3'd3, 32'h10, 32'd0);
    do_op(1, 0, 1, 3'd4, 32'h10, 32'h77);

    // Reset landing on the RMW write cycle must suppress the write.
    do_op(1, 0, 1, 3'd2, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    funct3 = 3'd1; addr = 32'h22; wdata = 32'h1234;
    @(negedge clk);
    chk("rmw_read_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_rmw_no_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    do_op(1, 1, 0, 3'd2, 32'h20, 32'd0);

    // Write wins over read; idle cycles do nothing.
    do_op(1, 1, 1, 3'd2, 32'h24, 32'h12345678);
    do_op(1, 1, 0, 3'd2, 32'h24, 32'd0);
    repeat (3) do_op(0, 1, 1, 3'd0, 32'h30, 32'hFFFFFFFF);

    // Random traffic over a small window of words, with upper address bits scrambled.
    for (int n = 0; n < 300; n++) begin
      do_op(1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 3'($urandom),
            ($urandom & 32'hFFFFFC00) | $urandom_range(0, 63), $urandom);
    end

    repeat (4) do_op(0, 0, 0, 3'd0, 32'd0, 32'd0);
    chk("drain_writes", 32'(wr_q.size()), 32'd0);
    chk("drain_loads", 32'(ld_q.size()), 32'd0);
    chk("drain_errors", 32'(er_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
